// File: rtl/data_io_mem_unit_if.sv
// Bus between the execution stage and the data/I/O memory unit.
// Build option: DMEM_BYTE_LANES_EN adds the dm_size store-width field.

interface data_io_mem_unit_if;
    logic [31:0] addr;
    logic [31:0] wr_dat;
    logic        dm_cs;
    logic        dm_wr;
    logic        dm_rd;
    logic        io_cs;
    logic        io_wr;
    logic        io_rd;
    logic        inta;
`ifdef DMEM_BYTE_LANES_EN
    logic [1:0]  dm_size;
`endif
    logic [31:0] dm_rdat;
    logic [31:0] io_rdat;
    logic        io_busy;
    logic        io_done;
    logic        misalign;
    logic        intr;

    // Requester side (execution stage / control unit)
    modport master (
        output addr, wr_dat, dm_cs, dm_wr, dm_rd, io_cs, io_wr, io_rd, inta,
`ifdef DMEM_BYTE_LANES_EN
        output dm_size,
`endif
        input  dm_rdat, io_rdat, io_busy, io_done, misalign, intr
    );

    // Memory unit side
    modport slave (
        input  addr, wr_dat, dm_cs, dm_wr, dm_rd, io_cs, io_wr, io_rd, inta,
`ifdef DMEM_BYTE_LANES_EN
        input  dm_size,
`endif
        output dm_rdat, io_rdat, io_busy, io_done, misalign, intr
    );
endinterface

// File: rtl/data_io_mem_unit.sv
// Memory stage: big-endian byte-addressed data memory with 1-cycle reads,
// plus an I/O space behind a fixed wait-state handshake. An I/O write of
// nonzero data to 0xFFC raises a level interrupt held until inta.
// Build option: DMEM_BYTE_LANES_EN enables halfword/byte stores (dm_size).

module data_io_mem_unit #(
    parameter int DM_AW   = 12,
    parameter int IO_AW   = 12,
    parameter int IO_WAIT = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    data_io_mem_unit_if.slave bus
);

    localparam int DM_WORDS = 2 ** (DM_AW - 2);
    localparam int IO_WORDS = 2 ** (IO_AW - 2);
    localparam logic [IO_AW-1:0] INTR_ADDR = IO_AW'(12'hFFC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } io_state_e;

    // Storage
    logic [31:0] dmem  [DM_WORDS];
    logic [31:0] iomem [IO_WORDS];

    // Data memory decode
    logic             dm_req;
    logic             dm_aligned;
    logic             dm_we;
    logic             dm_re;
    logic [3:0]       dm_be;      // bit 3 = byte lane [31:24] (address offset 0)
    logic [31:0]      dm_wdat;
    logic [DM_AW-3:0] dm_idx;

    // I/O path
    io_state_e        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             io_req;
    logic             io_aligned;
    logic             io_start;
    logic             io_exec;
    logic             io_busy;
    logic             io_done;
    logic [IO_AW-3:0] lat_idx;
    logic [31:0]      lat_dat;
    logic             lat_wr;

    logic [31:0]      dm_rdat_q;
    logic [31:0]      io_rdat_q;
    logic             misalign_q;
    logic             intr_q;
    logic             misalign_d;

    // Upper address bits beyond both spaces are deliberately ignored
    logic unused_addr;
    assign unused_addr = ^bus.addr;

    assign dm_req = bus.dm_cs & (bus.dm_rd | bus.dm_wr);
    assign dm_idx = bus.addr[DM_AW-1:2];

`ifdef DMEM_BYTE_LANES_EN
    // Store width selects lanes and replicates the low bits of wr_dat onto them
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        dm_be      = 4'b1111;
        dm_wdat    = bus.wr_dat;
        dm_aligned = (bus.addr[1:0] == 2'b00);
        case (bus.dm_size)
            2'b01: begin
                dm_aligned = ~bus.addr[0];
                dm_wdat    = {2{bus.wr_dat[15:0]}};
                dm_be      = bus.addr[1] ? 4'b0011 : 4'b1100;
            end
            2'b10: begin
                dm_aligned = 1'b1;
                dm_wdat    = {4{bus.wr_dat[7:0]}};
                dm_be      = 4'b1000 >> bus.addr[1:0];
            end
            default: ;
        endcase
    end
`else
    assign dm_be      = 4'b1111;
    assign dm_wdat    = bus.wr_dat;
    assign dm_aligned = (bus.addr[1:0] == 2'b00);
`endif

    // Write wins over read; misaligned accesses do nothing
    assign dm_we = dm_req & dm_aligned & bus.dm_wr;
    assign dm_re = dm_req & dm_aligned & bus.dm_rd & ~bus.dm_wr;

    // A data memory select masks any I/O request in the same cycle
    assign io_req     = bus.io_cs & (bus.io_rd | bus.io_wr) & ~bus.dm_cs;
    assign io_aligned = (bus.addr[1:0] == 2'b00);

    assign misalign_d = (dm_req & ~dm_aligned)
                      | (io_req & ~io_aligned & (state_q == S_IDLE));

    // Data memory array write, lane by lane
    // NOTE: the arrays carry no reset; their contents are undefined until written.
    always_ff @(posedge sys_clk) begin
        if (dm_we) begin
            for (int i = 0; i < 4; i++) begin
                if (dm_be[i]) dmem[dm_idx][i*8 +: 8] <= dm_wdat[i*8 +: 8];
            end
        end
    end

    // Registered data memory read word, held until the next read
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (sys_rst)    dm_rdat_q <= '0;
        else if (dm_re) dm_rdat_q <= dmem[dm_idx];
    end

    // I/O next-state, counter and handshake outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        io_start = 1'b0;
        io_exec  = 1'b0;
        io_busy  = 1'b0;
        io_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (io_req && io_aligned) begin
                    io_start = 1'b1;
                    cnt_d    = 4'(IO_WAIT);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                io_busy = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                // The access is performed at the edge entering DONE so its
                // results are visible together with io_done
                if (cnt_q == 4'd1) begin
                    io_exec = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                io_done = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // I/O state, request latch, read data, interrupt and misalign pulse
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lat_idx    <= '0;
            lat_dat    <= '0;
            lat_wr     <= 1'b0;
            io_rdat_q  <= '0;
            intr_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
            if (io_start) begin
                lat_idx <= bus.addr[IO_AW-1:2];
                lat_dat <= bus.wr_dat;
                lat_wr  <= bus.io_wr;
            end
            if (io_exec && !lat_wr) io_rdat_q <= iomem[lat_idx];
            // A write to the interrupt register beats a same-cycle acknowledge
            if (io_exec && lat_wr && lat_idx == INTR_ADDR[IO_AW-1:2])
                intr_q <= (lat_dat != 32'd0);
            else if (bus.inta)
                intr_q <= 1'b0;
        end
    end

    // I/O array write, committed when the access completes
    always_ff @(posedge sys_clk) begin
        if (io_exec && lat_wr) iomem[lat_idx] <= lat_dat;
    end

    assign bus.dm_rdat  = dm_rdat_q;
    assign bus.io_rdat  = io_rdat_q;
    assign bus.io_busy  = io_busy;
    assign bus.io_done  = io_done;
    assign bus.misalign = misalign_q;
    assign bus.intr     = intr_q;

endmodule
